// File: rtl/relay_station_pkg.sv
// ----------------------------------------------------------------------------
// relay_station_pkg
// Shared parameter defaults and sizing helpers for the credit-based relay
// station (relay_station_credit and its receive buffer).
//
// No ports. Exports:
//   DATA_WIDTH_DEFAULT, LEVEL_DEFAULT, DEPTH_DEFAULT : default parameters
//   calc_cap(depth, level) : receive capacity = depth + 2*level + 2
//   credit_width(cap)      : bits needed to hold a count of 0..cap
// ----------------------------------------------------------------------------
package relay_station_pkg;

    localparam int DATA_WIDTH_DEFAULT = 32;
    localparam int LEVEL_DEFAULT      = 2;
    localparam int DEPTH_DEFAULT      = 2;

    // The round trip is LEVEL forward stages + buffer write + LEVEL return
    // stages + counter update, so 2*LEVEL+2 credits are always in flight at
    // full throughput; DEPTH adds slack on top of that.
    function automatic int calc_cap(input int depth, input int level);
        return depth + 2 * level + 2;
    endfunction

    function automatic int credit_width(input int cap);
        return $clog2(cap + 1);
    endfunction

endpackage

// File: rtl/relay_station_credit_fifo.sv
// ----------------------------------------------------------------------------
// relay_station_credit_fifo
// First-word-fall-through circular buffer of CAP entries sitting at the
// receive end of the relay station. The head word is held in a register so
// that dout is reset to zero and stays stable until it is popped.
//
// Optional feature: define RELAY_STATION_CREDIT_OVERFLOW_CHECK_EN to flag
// (sticky) and drop any write arriving while the buffer is full and not
// being popped. Without it, overflow is tied low and no check exists.
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   wr_en    in   arriving word valid
//   wr_data  in   arriving word
//   rd_en    in   pop of the head (only asserted while empty_n=1)
//   empty_n  out  head word valid
//   dout     out  head word
//   overflow out  sticky write-into-full flag
// ----------------------------------------------------------------------------
module relay_station_credit_fifo
    import relay_station_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int CAP        = calc_cap(DEPTH_DEFAULT, LEVEL_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic                  empty_n,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  overflow
);

    localparam int PW = (CAP > 1) ? $clog2(CAP) : 1;
    localparam int CW = credit_width(CAP);

    logic [DATA_WIDTH-1:0] mem [CAP];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         rd_ptr_inc;
    logic [PW-1:0]         head_idx;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic                  wr_acc;
    logic                  load_head;
    logic                  head_from_in;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(CAP - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef RELAY_STATION_CREDIT_OVERFLOW_CHECK_EN
    logic full_block;
    logic overflow_q;

    // A pop in the same cycle frees the slot, so that arrival is legal.
    assign full_block = (count == CW'(CAP)) && !rd_en;
    assign wr_acc     = wr_en && !full_block;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else if (wr_en && full_block) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`else
    assign wr_acc   = wr_en;
    assign overflow = 1'b0;
`endif

    assign rd_ptr_inc = ptr_inc(rd_ptr);
    assign empty_n    = (count != '0);

    always_comb begin
        count_nxt = count;
        if (wr_acc && !rd_en) begin
            count_nxt = count + 1'b1;
        end else if (!wr_acc && rd_en) begin
            count_nxt = count - 1'b1;
        end
    end

    // The head register reloads whenever the head changes: on a pop, or on
    // the first write into an empty buffer. If the new head is the very word
    // being written this cycle it bypasses the memory.
    assign head_idx     = rd_en ? rd_ptr_inc : rd_ptr;
    assign head_from_in = wr_acc && (count == (rd_en ? CW'(1) : CW'(0)));
    assign load_head    = (count_nxt != '0) && (rd_en || (count == '0));

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr_inc;
            end
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout <= '0;
        end else if (load_head) begin
            dout <= head_from_in ? wr_data : mem[head_idx];
        end
    end

endmodule

// File: rtl/relay_station_credit.sv
// ----------------------------------------------------------------------------
// relay_station_credit
// Credit-flow-controlled relay station: the write side holds CAP credits and
// may push while any remain. Pushed words travel LEVEL register stages to a
// CAP-entry FWFT receive buffer; every pop sends one credit token back
// through LEVEL return stages to the write-side counter. CAP covers the full
// round trip, so a reader popping every cycle sustains one word per cycle.
//
// Optional feature: RELAY_STATION_CREDIT_OVERFLOW_CHECK_EN enables the
// sticky receive-buffer overflow flag (if_overflow); otherwise it reads 0.
//
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   if_full_n    out  write side may push (credit counter non-zero)
//   if_write_ce  in   write clock-enable qualifier
//   if_write     in   write request
//   if_din       in   write data
//   if_empty_n   out  read data valid (first-word-fall-through)
//   if_read_ce   in   read clock-enable qualifier
//   if_read      in   read acknowledge
//   if_dout      out  head-of-queue data
//   if_overflow  out  sticky receive-buffer overflow flag
// ----------------------------------------------------------------------------
module relay_station_credit
    import relay_station_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int LEVEL      = LEVEL_DEFAULT,
    parameter int DEPTH      = DEPTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_overflow
);

    localparam int CAP = calc_cap(DEPTH, LEVEL);
    localparam int CW  = credit_width(CAP);
    localparam int NS  = (LEVEL > 0) ? LEVEL : 1;

    logic [CW-1:0]         credit_cnt;
    logic                  push;
    logic                  pop;
    logic                  credit_ret;
    logic                  arr_vld;
    logic [DATA_WIDTH-1:0] arr_data;

    // Stage n of each pipeline is element n; stage 1 takes the push/pop.
    logic                  vld_p  [1:NS];
    logic [DATA_WIDTH-1:0] data_p [1:NS];
    logic                  ret_p  [1:NS];

    assign push      = if_write & if_write_ce & if_full_n;
    assign pop       = if_read & if_read_ce & if_empty_n;
    assign if_full_n = (credit_cnt != '0);

    // ---- forward path: push -> stage 1 .. stage LEVEL -> receive buffer ----
    for (genvar i = 1; i <= LEVEL; i++) begin : g_fwd
        if (i == 1) begin : g_first
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    vld_p[i] <= 1'b0;
                end else begin
                    vld_p[i] <= push;
                end
            end

            always_ff @(posedge clk) begin
                data_p[i] <= if_din;
            end
        end else begin : g_rest
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    vld_p[i] <= 1'b0;
                end else begin
                    vld_p[i] <= vld_p[i-1];
                end
            end

            always_ff @(posedge clk) begin
                data_p[i] <= data_p[i-1];
            end
        end
    end

    // ---- return path: pop -> stage 1 .. stage LEVEL -> credit counter ----
    for (genvar i = 1; i <= LEVEL; i++) begin : g_ret
        if (i == 1) begin : g_first
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    ret_p[i] <= 1'b0;
                end else begin
                    ret_p[i] <= pop;
                end
            end
        end else begin : g_rest
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    ret_p[i] <= 1'b0;
                end else begin
                    ret_p[i] <= ret_p[i-1];
                end
            end
        end
    end

    // With no stages the push feeds the buffer and the pop feeds the
    // counter directly; each is still registered once at its destination.
    if (LEVEL == 0) begin : g_direct
        assign arr_vld    = push;
        assign arr_data   = if_din;
        assign credit_ret = pop;
    end else begin : g_piped
        assign arr_vld    = vld_p[LEVEL];
        assign arr_data   = data_p[LEVEL];
        assign credit_ret = ret_p[LEVEL];
    end

    // A push and a returning credit in the same cycle cancel out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            credit_cnt <= CW'(CAP);
        end else begin
            case ({push, credit_ret})
                2'b10:   credit_cnt <= credit_cnt - 1'b1;
                2'b01:   credit_cnt <= credit_cnt + 1'b1;
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

    relay_station_credit_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .CAP        (CAP)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (arr_vld),
        .wr_data  (arr_data),
        .rd_en    (pop),
        .empty_n  (if_empty_n),
        .dout     (if_dout),
        .overflow (if_overflow)
    );

endmodule

// File: tb/tb_relay_station_credit.sv
module tb_relay_station_credit;

    localparam int L   = 2;
    localparam int CAP = 8;

    logic        clk;
    logic        reset_n;
    logic        if_full_n;
    logic        if_write_ce;
    logic        if_write;
    logic [31:0] if_din;
    logic        if_empty_n;
    logic        if_read_ce;
    logic        if_read;
    logic [31:0] if_dout;
    logic        if_overflow;

    relay_station_credit #(
        .DATA_WIDTH (32),
        .LEVEL      (L),
        .DEPTH      (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .if_full_n   (if_full_n),
        .if_write_ce (if_write_ce),
        .if_write    (if_write),
        .if_din      (if_din),
        .if_empty_n  (if_empty_n),
        .if_read_ce  (if_read_ce),
        .if_read     (if_read),
        .if_dout     (if_dout),
        .if_overflow (if_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        int          rdy;
    } ent_t;

    ent_t mq[$];     // scoreboard: expected words and the cycle they appear
    int   rq[$];     // cycles at which a returned credit becomes visible
    int   m_credit;
    int   cyc;
    int   n_asrt;
    int   n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        rq.delete();
        m_credit = CAP;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, then
    // advance the model and the clock. Called #1 after a rising edge.
    task automatic step(input logic w, input logic wce, input logic [31:0] d,
                        input logic r, input logic rce);
        logic ef;
        logic ee;
        ent_t e;
        if_write    = w;
        if_write_ce = wce;
        if_din      = d;
        if_read     = r;
        if_read_ce  = rce;
        ef = (m_credit != 0);
        ee = (mq.size() > 0) && (mq[0].rdy <= cyc);
        chk("full_n", {31'd0, if_full_n}, {31'd0, ef});
        chk("empty_n", {31'd0, if_empty_n}, {31'd0, ee});
        if (ee) chk("dout", if_dout, mq[0].d);
        if (r && rce && ee) begin
            void'(mq.pop_front());
            rq.push_back(cyc + L + 1);
        end
        if (w && wce && ef) begin
            e.d   = d;
            e.rdy = cyc + L + 1;
            mq.push_back(e);
            m_credit--;
        end
        @(posedge clk);
        #1;
        cyc++;
        while (rq.size() > 0 && rq[0] <= cyc) begin
            void'(rq.pop_front());
            m_credit++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_full_n"}, {31'd0, if_full_n}, 32'd1);
        chk({tag, "_empty_n"}, {31'd0, if_empty_n}, 32'd0);
        chk({tag, "_dout"}, if_dout, 32'd0);
        chk({tag, "_overflow"}, {31'd0, if_overflow}, 32'd0);
    endtask

    initial begin
        n_asrt      = 0;
        n_fail      = 0;
        cyc         = 0;
        reset_n     = 1'b0;
        if_write    = 1'b0;
        if_write_ce = 1'b0;
        if_din      = '0;
        if_read     = 1'b0;
        if_read_ce  = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("rst");

        // Single push at cycle 0; visible at cycle L+1 = 3.
        cyc = 0;
        step(1'b1, 1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("single_cycle", cyc, 32'd3);
        chk("single_empty_n", {31'd0, if_empty_n}, 32'd1);
        chk("single_dout", if_dout, 32'hA5A5_A5A5);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        repeat (L + 2) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Stalled reader: only CAP writes get in, then full_n drops.
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 32'h1000 + i, 1'b0, 1'b0);
        chk("fill_full_n", {31'd0, if_full_n}, 32'd0);
        chk("fill_head", if_dout, 32'h1000);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        repeat (L + 2) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("fill_credit_back", {31'd0, if_full_n}, 32'd1);

        // Write request without clock enable: nothing goes through.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'hDEAD_0000 + i, 1'b0, 1'b0);
        chk("ce_empty_n", {31'd0, if_empty_n}, 32'd0);

        // Read clock enable low with data waiting: head stays put.
        step(1'b1, 1'b1, 32'h2222_0001, 1'b0, 1'b0);
        repeat (L + 1) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // Full-rate streaming.
        for (int i = 0; i < 1000; i++) step(1'b1, 1'b1, 32'h3000_0000 + i, 1'b1, 1'b1);
        for (int i = 0; i < 2 * L + 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // Random mix of writes, reads and enables.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
        for (int i = 0; i < CAP + 2 * L + 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // Reset mid-cycle with words still in flight.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 32'h5000 + i, 1'b0, 1'b0);
        if_write = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #3 reset_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        cyc++;
        check_reset_outputs("postrst");
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 32'h6000 + i, 1'b0, 1'b0);
        chk("postrst_full_n", {31'd0, if_full_n}, 32'd0);
        chk("postrst_head", if_dout, 32'h6000);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

`ifdef RELAY_STATION_CREDIT_OVERFLOW_CHECK_EN
        // One extra credit lets a ninth word reach a full buffer.
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        force dut.credit_cnt = 4'd9;
        if_read     = 1'b0;
        if_write_ce = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if_write = 1'b1;
            if_din   = 32'h7000 + i;
            @(posedge clk);
            #1;
        end
        if_write = 1'b0;
        repeat (L - 1) @(posedge clk);
        #1;
        chk("ovf_before", {31'd0, if_overflow}, 32'd0);
        @(posedge clk);
        #1;
        chk("ovf_set", {31'd0, if_overflow}, 32'd1);
        chk("ovf_head", if_dout, 32'h7000);
        repeat (5) @(posedge clk);
        #1;
        chk("ovf_hold", {31'd0, if_overflow}, 32'd1);
        release dut.credit_cnt;
        reset_n = 1'b0;
        #1;
        chk("ovf_clear", {31'd0, if_overflow}, 32'd0);
        #1 reset_n = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/relay_station_credit.md
RELAY_STATION_CREDIT -- requirements
Module: relay_station_credit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: payload width in bits, minimum 1.
REQ-002 SHALL have parameter LEVEL, default 2: register stages in the forward data path and in the credit-return path, range 0..8.
REQ-003 SHALL have parameter DEPTH, default 2: extra buffering beyond round trip; total capacity CAP = DEPTH + 2*LEVEL + 2.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port if_full_n, output, 1: write side may accept (at least one credit held).
REQ-007 SHALL have port if_write_ce, input, 1: write clock-enable qualifier.
REQ-008 SHALL have port if_write, input, 1: write request.
REQ-009 SHALL have port if_din, input, DATA_WIDTH: write data.
REQ-010 SHALL have port if_empty_n, output, 1: read data valid (FWFT).
REQ-011 SHALL have port if_read_ce, input, 1: read clock-enable qualifier.
REQ-012 SHALL have port if_read, input, 1: read acknowledge.
REQ-013 SHALL have port if_dout, output, DATA_WIDTH: head-of-queue data.
REQ-014 SHALL have port if_overflow, output, 1: sticky receive-buffer overflow flag.

Function
REQ-015 SHALL define push = if_write & if_write_ce & if_full_n; push when if_full_n=0 SHALL be ignored.
REQ-016 SHALL keep a sender credit counter of width clog2(CAP+1), initialised to CAP; push decrements, returned credit increments, both together leave it unchanged.
REQ-017 SHALL drive if_full_n = (credit counter != 0) from registered state only; no combinational path from the read side.
REQ-018 SHALL carry pushed {valid, data} through LEVEL forward registers; LEVEL=0 SHALL write directly into the receive buffer.
REQ-019 SHALL hold a receive FWFT circular buffer of CAP entries; pointers wrap from CAP-1 to 0.
REQ-020 SHALL raise if_empty_n and present the word on if_dout exactly LEVEL+1 cycles after its push into an empty buffer.
REQ-021 SHALL define pop = if_read & if_read_ce & if_empty_n; pop advances the head next cycle; if_dout SHALL stay stable while if_empty_n=1 and no pop.
REQ-022 SHALL inject one credit token per pop into a LEVEL-stage return pipeline; the counter SHALL increment LEVEL+1 cycles after the pop.
REQ-023 SHALL handle simultaneous arrival and pop in one cycle with occupancy unchanged and no data loss, including at full and at one entry.
REQ-024 SHALL sustain one word per cycle indefinitely when the reader pops every cycle.
REQ-025 SHALL deliver words in push order with no duplication or loss.

Reset
REQ-026 SHALL, on reset_n low, immediately clear all pipeline valids, credit tokens and buffer pointers, set credits to CAP, and drive if_full_n=1, if_empty_n=0, if_dout=0, if_overflow=0.
REQ-027 SHALL discard in-flight words on reset mid-stream; the first post-reset push SHALL be the first word read.
REQ-028 SHALL leave data registers without reset except if_dout.

Configuration
REQ-029 SHALL, with RELAY_STATION_CREDIT_OVERFLOW_CHECK_EN defined, set if_overflow on any arrival into a full buffer and hold it until reset; that arrival SHALL be dropped.
REQ-030 SHALL, without the macro, tie if_overflow to 0 and omit the check logic.

Structure
REQ-031 SHALL place the CAP formula, credit-width function and default parameter values in relay_station_pkg.
REQ-032 SHALL implement the receive buffer as sub-module relay_station_credit_fifo; both pipelines SHALL be generate loops in the top.

Verification (DATA_WIDTH=32, LEVEL=2, DEPTH=2, CAP=8)
REQ-033 SHALL check: reset, then a single push of 0xA5A5A5A5 at cycle 0 -> if_empty_n=1 with if_dout=0xA5A5A5A5 at cycle 3.
REQ-034 SHALL check: reader stalled, writes every cycle -> exactly 8 accepted, if_full_n=0 after the 8th; a later read of 8 returns them in order.
REQ-035 SHALL check: write and read every cycle for 1000 cycles -> 1000 words in order, if_full_n never 0 after warm-up.
REQ-036 SHALL check: if_write=1 with if_write_ce=0 for 10 cycles -> nothing delivered, if_full_n stays 1.
REQ-037 SHALL check: reset_n low mid-clock with 5 words in flight -> outputs reach reset values before the next edge; after release 8 pushes are accepted again.
REQ-038 SHALL check: macro defined, credit counter forced to 9 -> the 9th arrival sets if_overflow=1, which holds until reset.
